// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs register/immediate fields into a 32-bit word and queues it in a small FIFO
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               rd,
  input  logic                     wr,
  input  logic [12:0]              imm,
  output logic [31:0]              out_word,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              issued
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] depthWords = LW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [LW-1:0] count;
  logic [15:0]   popCount;
  logic [31:0]   encWord;
  logic          accept;
  logic          pop;

  // Without a write the destination and immediate fields are meaningless, so they are cleared.
  assign encWord = {wr ? imm : 13'd0, wr, wr ? rd : 5'd0, rt, 1'b0, rs, 2'b00};

  assign in_ready  = (count < depthWords);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_word  = out_valid ? mem[rdPtr] : 32'd0;
  assign level     = count;
  assign issued    = popCount;

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      popCount <= 16'd0;
    end else begin
      if (accept) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr    <= rdPtr + 1'b1;
        popCount <= popCount + 16'd1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (accept && !reset) mem[wrPtr] <= encWord;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized self-checking bench for instr_encoder against a queue model
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        wr;
  logic [12:0] imm;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic [15:0] issued;

  int total = 0;
  int bad = 0;

  logic [31:0] q[$];
  logic [15:0] mIssued = 16'd0;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .wr(wr), .imm(imm),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .issued(issued)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] refEncode(int rsV, int rtV, int rdV, int wrV, int immV);
    longint w;
    w = longint'(rsV) * 4 + longint'(rtV) * 256;
    if (wrV != 0) w = w + longint'(rdV) * 8192 + 262144 + longint'(immV) * 524288;
    return 32'(w);
  endfunction

  task automatic randFields();
    rs  = 5'($urandom);
    rt  = 5'($urandom);
    rd  = 5'($urandom);
    wr  = 1'($urandom);
    imm = 13'($urandom);
  endtask

  task automatic tick();
    bit acc;
    bit pop;
    logic [31:0] w;
    acc = in_valid && (q.size() < DEPTH);
    pop = out_ready && (q.size() > 0);
    w = refEncode(int'(rs), int'(rt), int'(rd), int'(wr), int'(imm));
    @(posedge clock);
    #1;
    if (reset) begin
      q.delete();
      mIssued = 16'd0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        mIssued = mIssued + 16'd1;
      end
      if (acc) q.push_back(w);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    randFields();
    tick();
    reset = 1'b0; in_valid = 1'b0;
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_word !== 32'd0) begin bad++; $display("FAIL reset_out_word got=%h exp=0", out_word); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (issued !== 16'd0) begin bad++; $display("FAIL reset_issued got=%0d exp=0", issued); end
    out_ready = 1'b1;
    tick();
    total++; if (issued !== 16'd0 || level !== 3'd0) begin
      bad++; $display("FAIL empty_pop issued=%0d level=%0d exp=0/0", issued, level);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_encode();
    doReset();
    rs = 5'd3; rt = 5'd5; rd = 5'd7; wr = 1'b1; imm = 13'd1;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    total++; if (out_word !== 32'h000CE50C) begin bad++; $display("FAIL enc_basic got=%h exp=000ce50c", out_word); end
    total++; if (out_valid !== 1'b1 || level !== 3'd1) begin
      bad++; $display("FAIL enc_basic_state valid=%b level=%0d exp=1/1", out_valid, level);
    end
    tick();
    total++; if (out_word !== 32'h000CE50C) begin bad++; $display("FAIL enc_hold got=%h exp=000ce50c", out_word); end
    doReset();
    rs = 5'd31; rt = 5'd31; rd = 5'd31; wr = 1'b0; imm = 13'h1FFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (out_word !== 32'h00001F7C) begin bad++; $display("FAIL enc_wr0 got=%h exp=00001f7c", out_word); end
  endtask

  task automatic test_full();
    logic [31:0] oldest;
    doReset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      randFields();
      tick();
    end
    oldest = q[0];
    total++; if (level !== 3'(DEPTH) || in_ready !== 1'b0) begin
      bad++; $display("FAIL full_state level=%0d in_ready=%b exp=%0d/0", level, in_ready, DEPTH);
    end
    randFields();
    tick();
    total++; if (level !== 3'(DEPTH) || out_word !== oldest) begin
      bad++; $display("FAIL full_reject level=%0d word=%h exp=%0d/%h", level, out_word, DEPTH, oldest);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_word !== oldest) begin bad++; $display("FAIL full_oldest got=%h exp=%h", out_word, oldest); end
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || level !== 3'(q.size())) begin
      bad++; $display("FAIL full_pop in_ready=%b level=%0d exp=1/%0d", in_ready, level, q.size());
    end
    total++; if (out_word !== q[0]) begin bad++; $display("FAIL full_next got=%h exp=%h", out_word, q[0]); end
  endtask

  task automatic test_back_to_back();
    doReset();
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      randFields();
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      randFields();
      total++; if (out_word !== q[0]) begin bad++; $display("FAIL b2b_order cyc=%0d got=%h exp=%h", i, out_word, q[0]); end
      tick();
      total++; if (level !== 3'd2) begin bad++; $display("FAIL b2b_level cyc=%0d got=%0d exp=2", i, level); end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (issued !== 16'd10) begin bad++; $display("FAIL b2b_issued got=%0d exp=10", issued); end
  endtask

  task automatic test_reset_mid();
    doReset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randFields();
      tick();
    end
    out_ready = 1'b1; reset = 1'b1;
    randFields();
    tick();
    reset = 1'b0; in_valid = 1'b0;
    total++; if (level !== 3'd0 || out_valid !== 1'b0 || issued !== 16'd0) begin
      bad++; $display("FAIL mid_reset level=%0d valid=%b issued=%0d exp=0/0/0", level, out_valid, issued);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_valid !== 1'b0 || out_word !== 32'd0) begin
        bad++; $display("FAIL mid_reset_stale cyc=%0d valid=%b word=%h exp=0/0", i, out_valid, out_word);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] expWord;
    int errs;
    doReset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
      randFields();
      tick();
      expWord = (q.size() > 0) ? q[0] : 32'd0;
      total++;
      if (out_word !== expWord || level !== 3'(q.size()) || out_valid !== (q.size() > 0)
          || in_ready !== (q.size() < DEPTH) || issued !== mIssued) begin
        bad++; errs++;
        if (errs < 10)
          $display("FAIL random cyc=%0d word=%h/%h level=%0d/%0d issued=%0d/%0d", i, out_word, expWord,
                   level, q.size(), issued, mIssued);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_issued_wrap();
    int pops;
    int cyc;
    doReset();
    in_valid = 1'b1; out_ready = 1'b1;
    rs = 5'd1; rt = 5'd2; rd = 5'd3; wr = 1'b1; imm = 13'd4;
    pops = 0; cyc = 0;
    while (pops < 65535 && cyc < 70000) begin
      if (q.size() > 0) pops++;
      tick();
      cyc++;
    end
    total++; if (issued !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", issued); end
    while (pops < 65536 && cyc < 70000) begin
      if (q.size() > 0) pops++;
      tick();
      cyc++;
    end
    total++; if (pops != 65536) begin bad++; $display("FAIL wrap_budget pops=%0d exp=65536", pops); end
    total++; if (issued !== 16'd0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", issued); end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    rs = '0; rt = '0; rd = '0; wr = 1'b0; imm = '0;
    test_reset();
    test_encode();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_issued_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The parameter DEPTH, default 4, SHALL set the output FIFO depth in words and SHALL be a power of two, at least 2.
REQ-002 The port clock, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 The port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-004 The port in_valid, input, 1 bit, SHALL mark a valid field set from the requester.
REQ-005 The port in_ready, output, 1 bit, SHALL indicate that the block accepts a field set this cycle.
REQ-006 The port rs, input, 5 bits, SHALL carry the first source register index.
REQ-007 The port rt, input, 5 bits, SHALL carry the second source register index.
REQ-008 The port rd, input, 5 bits, SHALL carry the destination register index.
REQ-009 The port wr, input, 1 bit, SHALL carry the write-enable flag.
REQ-010 The port imm, input, 13 bits, SHALL carry the immediate payload.
REQ-011 The port out_word, output, 32 bits, SHALL carry the encoded instruction word at the FIFO head.
REQ-012 The port out_valid, output, 1 bit, SHALL indicate that out_word holds a valid word.
REQ-013 The port out_ready, input, 1 bit, SHALL indicate that the consumer takes out_word this cycle.
REQ-014 The port level, output, clog2(DEPTH)+1 bits, SHALL report the current FIFO occupancy.
REQ-015 The port issued, output, 16 bits, SHALL count the words popped since reset.

Function
REQ-016 An accept SHALL occur when in_valid=1 and in_ready=1; a pop SHALL occur when out_valid=1 and out_ready=1.
REQ-017 Encoding SHALL be: [1:0]=00, [6:2]=rs, [7]=0, [12:8]=rt, [17:13]=rd, [18]=wr, [31:19]=imm.
REQ-018 When wr=0, the encoder SHALL force [17:13] and [31:19] to zero, whatever rd and imm hold.
REQ-019 Encoding SHALL be computed from the inputs in the accept cycle, and the encoded word SHALL be written into the FIFO at that clock edge.
REQ-020 Latency SHALL be one cycle: a word accepted at edge N is visible on out_word with out_valid=1 after edge N; no combinational input-to-output bypass.
REQ-021 in_ready SHALL equal (level < DEPTH), a registered-state function only, independent of out_ready.
REQ-022 out_valid SHALL equal (level != 0).
REQ-023 The FIFO SHALL deliver words in strict accept order; out_word SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 On a simultaneous accept and pop, level SHALL be unchanged and both pointers SHALL advance.
REQ-025 When full, no accept SHALL occur; a pop in that cycle SHALL make in_ready=1 in the next cycle.
REQ-026 When empty, a pop SHALL not occur; out_ready=1 SHALL be ignored and issued SHALL not change.
REQ-027 The read and write pointers SHALL wrap modulo DEPTH.
REQ-028 issued SHALL increment by 1 per pop and wrap from 16'hFFFF to 0.
REQ-029 out_word SHALL be 0 whenever out_valid=0.

Reset
REQ-030 With reset=1 at a rising edge, the block SHALL set level=0, the pointers to 0 and issued=0, leaving out_valid=0, out_word=0 and in_ready=1 after that edge.
REQ-031 Reset SHALL take priority over a simultaneous accept or pop, and any buffered words SHALL be discarded.
REQ-032 FIFO storage contents SHALL need no reset.

Verification
REQ-033 Reset, then accept rs=3, rt=5, rd=7, wr=1, imm=1 with out_ready=0 -> the next cycle shows out_word=32'h000CE50C, out_valid=1 and level=1.
REQ-034 Accept rs=31, rt=31, rd=31, wr=0, imm=13'h1FFF -> out_word=32'h00001F7C, with the rd and imm fields zeroed.
REQ-035 Push 4 words with out_ready=0 -> level=4 and in_ready=0; a fifth in_valid is not accepted; one pop then gives in_ready=1 and the oldest word first.
REQ-036 Hold level=2 with in_valid=1 and out_ready=1 for 10 cycles -> level stays at 2, the order is preserved across the pointer wrap, and issued=10.
REQ-037 Assert reset while level=3 and a push and a pop are both requested -> level=0, out_valid=0 and issued=0 after the edge, with no stale word emitted later.
REQ-038 Perform 65536 pops -> issued wraps to 0.
